// File: rtl/cpu_step_controller.sv
// CPU clock-enable sequencer on clk_50M: single-step, free-run and burst modes with halt handling.
// The CPU never sees a derived clock; it advances only on cycles where cpu_ce is high.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting; a press steps once or starts a burst
// S_RUN   | free-run, one cpu_ce every DIV cycles
// S_BURST | counting down burst pulses at DIV spacing
// S_HALTED| CPU requested stop; a press with halt low returns to IDLE
module cpu_step_controller #(
    parameter int DIV          = 25_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 32
) (
    input  logic             clk_50M,
    input  logic             rst_n,
    input  logic             btn_step_n,
    input  logic             mode_run,
    input  logic             burst_en,
    input  logic [7:0]       burst_len,
    input  logic             halt,
    output logic             cpu_ce,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST, S_HALTED} state_t;

    state_t              state, state_nxt;
    logic                btn_meta, btn_sync, run_meta, run_s, burst_meta, burst_s;
    logic                btn_db, btn_db_q, press;
    logic [DB_W-1:0]     db_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [7:0]          remaining, rem_nxt;
    logic                ce_nxt, busy_nxt, halted_nxt;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= 1'b1;
            btn_sync   <= 1'b1;
            run_meta   <= 1'b0;
            run_s      <= 1'b0;
            burst_meta <= 1'b0;
            burst_s    <= 1'b0;
        end else begin
            btn_meta   <= btn_step_n;
            btn_sync   <= btn_meta;
            run_meta   <= mode_run;
            run_s      <= run_meta;
            burst_meta <= burst_en;
            burst_s    <= burst_meta;
        end
    end

    // Debounced value moves only after the synchronized input has disagreed for DEBOUNCE_CYC cycles
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            btn_db   <= 1'b1;
            btn_db_q <= 1'b1;
            press    <= 1'b0;
        end else begin
            btn_db_q <= btn_db;
            press    <= btn_db_q & ~btn_db;
            if (btn_sync == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                btn_db <= btn_sync;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign tick = ((state == S_RUN) || (state == S_BURST)) && (tick_cnt == TICK_W'(DIV - 1));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            remaining  <= '0;
            tick_cnt   <= '0;
            cpu_ce     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            cpu_ce    <= ce_nxt;
            busy      <= busy_nxt;
            halted    <= halted_nxt;
            if (cpu_ce)
                step_count <= step_count + CNT_W'(1);
            // Restarting the divider on every transition puts the first pulse DIV cycles after entry
            if ((state_nxt != state) || tick || !((state == S_RUN) || (state == S_BURST)))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        case (state)
            S_IDLE: begin
                if (halt)
                    state_nxt = S_HALTED;
                else if (run_s)
                    state_nxt = S_RUN;
                else if (press && burst_s && (burst_len != 8'd0)) begin
                    rem_nxt   = burst_len;
                    state_nxt = S_BURST;
                end
            end
            S_RUN: begin
                if (halt)
                    state_nxt = S_HALTED;
                else if (!run_s)
                    state_nxt = S_IDLE;
            end
            S_BURST: begin
                if (halt) begin
                    state_nxt = S_HALTED;
                    rem_nxt   = '0;
                end else if (tick) begin
                    rem_nxt = remaining - 8'd1;
                    if (remaining == 8'd1)
                        state_nxt = S_IDLE;
                end
            end
            S_HALTED: begin
                if (press && !halt)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ce_nxt = 1'b0;
        case (state)
            S_IDLE:  ce_nxt = !halt && !run_s && press && !burst_s;
            S_RUN:   ce_nxt = !halt && run_s && tick;
            S_BURST: ce_nxt = !halt && tick;
            default: ce_nxt = 1'b0;
        endcase
        busy_nxt   = (state_nxt == S_RUN) || (state_nxt == S_BURST);
        halted_nxt = (state_nxt == S_HALTED);
    end

endmodule

// File: tb/tb_cpu_step_controller.sv
// Self-checking bench for cpu_step_controller: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the sequencer.
module tb_cpu_step_controller;

    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int CNT_W = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BURST = 2;
    localparam int M_HALT  = 3;

    logic             clk_50M = 1'b0;
    logic             rst_n = 1'b0;
    logic             btn_step_n = 1'b1;
    logic             mode_run = 1'b0;
    logic             burst_en = 1'b0;
    logic [7:0]       burst_len = 8'd0;
    logic             halt = 1'b0;
    logic             cpu_ce, busy, halted;
    logic [CNT_W-1:0] step_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int lat;

    always #10 clk_50M = ~clk_50M;

    cpu_step_controller #(.DIV(DIV), .DEBOUNCE_CYC(DEB), .CNT_W(CNT_W)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .btn_step_n (btn_step_n),
        .mode_run   (mode_run),
        .burst_en   (burst_en),
        .burst_len  (burst_len),
        .halt       (halt),
        .cpu_ce     (cpu_ce),
        .busy       (busy),
        .halted     (halted),
        .step_count (step_count)
    );

    // Model: inputs seen through two-cycle delay lines, debounce as a stability count,
    // mode as an integer with an age counter since entry.
    bit m_btn_p1, m_btn_p2, m_run_p1, m_run_p2, m_bst_p1, m_bst_p2;
    bit m_db, m_db_old, m_press, m_ce;
    int m_stable, m_mode, m_age, m_left, m_count;

    task automatic model_reset();
        m_btn_p1 = 1; m_btn_p2 = 1;
        m_run_p1 = 0; m_run_p2 = 0; m_bst_p1 = 0; m_bst_p2 = 0;
        m_db = 1; m_db_old = 1; m_press = 0; m_stable = 0;
        m_mode = M_IDLE; m_age = 0; m_left = 0; m_ce = 0; m_count = 0;
    endtask

    task automatic model_step();
        int  n_mode, n_left;
        bit  n_ce, n_press, tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick   = ((m_mode == M_RUN) || (m_mode == M_BURST)) && ((m_age % DIV) == DIV - 1);
        n_mode = m_mode; n_left = m_left; n_ce = 0;
        case (m_mode)
            M_IDLE: begin
                if (halt) n_mode = M_HALT;
                else if (m_run_p2) n_mode = M_RUN;
                else if (m_press) begin
                    if (!m_bst_p2) n_ce = 1;
                    else if (burst_len != 0) begin n_left = burst_len; n_mode = M_BURST; end
                end
            end
            M_RUN: begin
                if (halt) n_mode = M_HALT;
                else if (!m_run_p2) n_mode = M_IDLE;
                else if (tick) n_ce = 1;
            end
            M_BURST: begin
                if (halt) begin n_mode = M_HALT; n_left = 0; end
                else if (tick) begin
                    n_ce = 1;
                    n_left = m_left - 1;
                    if (m_left == 1) n_mode = M_IDLE;
                end
            end
            default: if (m_press && !halt) n_mode = M_IDLE;
        endcase
        m_count = (m_count + int'(m_ce)) % (1 << CNT_W);
        m_age   = (n_mode == m_mode) ? m_age + 1 : 0;
        m_mode  = n_mode; m_ce = n_ce; m_left = n_left;

        n_press  = m_db_old && !m_db;
        m_db_old = m_db;
        if (m_btn_p2 != m_db) begin
            if (m_stable == DEB - 1) begin m_db = m_btn_p2; m_stable = 0; end
            else m_stable++;
        end else m_stable = 0;
        m_press = n_press;
        m_btn_p2 = m_btn_p1; m_btn_p1 = btn_step_n;
        m_run_p2 = m_run_p1; m_run_p1 = mode_run;
        m_bst_p2 = m_bst_p1; m_bst_p1 = burst_en;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk_50M);
        model_step();
        @(negedge clk_50M);
        check_val("cpu_ce", 32'(cpu_ce), 32'(m_ce));
        check_val("busy", 32'(busy), 32'((m_mode == M_RUN) || (m_mode == M_BURST)));
        check_val("halted", 32'(halted), 32'(m_mode == M_HALT));
        check_val("step_count", 32'(step_count), m_count);
        if (cpu_ce) pulses++;
    endtask

    task automatic press(input int lo, input int hi);
        btn_step_n = 1'b0;
        repeat (lo) cycle();
        btn_step_n = 1'b1;
        repeat (hi) cycle();
    endtask

    task automatic wait_busy(input int lim);
        for (int i = 0; i < lim; i++) begin
            cycle();
            if (busy) break;
        end
        check_val("busy_wait", 32'(busy), 1);
    endtask

    initial begin
        model_reset();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();

        // single step: latency and one pulse, none on release
        pulses = 0; lat = 0;
        btn_step_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (cpu_ce && lat == 0) lat = i;
        end
        btn_step_n = 1'b1;
        repeat (12) cycle();
        check_val("step_latency", lat, DEB + 4);
        check_val("step_pulses", pulses, 1);
        check_val("step_cnt_1", 32'(step_count), 1);

        // bounce shorter than the debounce window
        pulses = 0;
        repeat (5) begin
            btn_step_n = 1'b0; repeat (2) cycle();
            btn_step_n = 1'b1; repeat (2) cycle();
        end
        repeat (10) cycle();
        check_val("bounce_pulses", pulses, 0);
        check_val("bounce_cnt", 32'(step_count), 1);

        // free run for 40 cycles
        pulses = 0;
        mode_run = 1'b1;
        repeat (40) cycle();
        mode_run = 1'b0;
        repeat (12) cycle();
        check_val("run_pulses", pulses, 9);
        check_val("run_exit_busy", 32'(busy), 0);

        // burst of 3 with burst_len and mode_run changed mid-burst
        burst_en = 1'b1; burst_len = 8'd3;
        repeat (3) cycle();
        btn_step_n = 1'b0;
        wait_busy(20);
        burst_len = 8'd9; mode_run = 1'b1; btn_step_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (!busy) break;
        end
        check_val("burst_pulses", pulses, 3);
        cycle();
        check_val("run_after_burst", 32'(busy), 1);
        mode_run = 1'b0;
        repeat (8) cycle();
        burst_len = 8'd0;
        pulses = 0;
        press(8, 8);
        check_val("burst_zero_pulses", pulses, 0);
        check_val("burst_zero_busy", 32'(busy), 0);

        // halt on a RUN tick, then press handling while halted
        burst_en = 1'b0; mode_run = 1'b1;
        wait_busy(20);
        for (int i = 0; i < 20; i++) begin
            if (m_mode == M_RUN && (m_age % DIV) == DIV - 1) break;
            cycle();
        end
        halt = 1'b1; mode_run = 1'b0;
        cycle();
        check_val("halt_tick_ce", 32'(cpu_ce), 0);
        check_val("halt_entered", 32'(halted), 1);
        press(8, 8);
        check_val("halt_press_kept", 32'(halted), 1);
        halt = 1'b0;
        pulses = 0;
        press(8, 8);
        check_val("halt_exit", 32'(halted), 0);
        check_val("halt_exit_pulses", pulses, 0);

        // random mix of presses, bounces, mode changes and halts
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 5))
                0, 1: press(int'($urandom_range(1, 8)), int'($urandom_range(1, 8)));
                2: begin
                    mode_run = 1'($urandom_range(0, 1));
                    repeat (int'($urandom_range(1, 12))) cycle();
                end
                3: begin
                    burst_en  = 1'($urandom_range(0, 1));
                    burst_len = 8'($urandom_range(0, 4));
                    cycle();
                end
                4: begin
                    halt = 1'b1;
                    repeat (int'($urandom_range(1, 3))) cycle();
                    halt = 1'b0;
                    cycle();
                end
                default: repeat (int'($urandom_range(1, 10))) cycle();
            endcase
        end
        mode_run = 1'b0; halt = 1'b0; btn_step_n = 1'b1;
        repeat (10) cycle();

        // asynchronous reset in the middle of a burst
        burst_en = 1'b1; burst_len = 8'd5;
        repeat (3) cycle();
        btn_step_n = 1'b0;
        wait_busy(20);
        btn_step_n = 1'b1;
        repeat (6) cycle();
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_ce", 32'(cpu_ce), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_halted", 32'(halted), 0);
        check_val("rst_count", 32'(step_count), 0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        burst_en = 1'b0;
        pulses = 0;
        repeat (20) cycle();
        check_val("rst_no_pulse", pulses, 0);

        // step_count wrap
        repeat (255) press(6, 6);
        repeat (4) cycle();
        check_val("cnt_255", 32'(step_count), 255);
        press(6, 6);
        repeat (4) cycle();
        check_val("cnt_wrap", 32'(step_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
